// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared constants for the data-memory MMIO bridge
package dmem_mmio_pkg;

    localparam logic [27:0] MMIO_BASE_HI = 28'hFFFFFFF;

    localparam logic [3:0] OFF_CYC_LO    = 4'd0;
    localparam logic [3:0] OFF_CYC_HI    = 4'd1;
    localparam logic [3:0] OFF_TX_DATA   = 4'd2;
    localparam logic [3:0] OFF_TX_STATUS = 4'd3;
    localparam logic [3:0] OFF_LED       = 4'd4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// rtl/dmem_mmio_bridge.sv - splits the data-memory port between RAM and top-16-word MMIO
module dmem_mmio_bridge
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 12,
    parameter int FIFO_DEPTH    = 8,
    parameter int LED_WIDTH     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              address_dmem,
    input  logic [31:0]              data,
    input  logic                     wren,
    output logic [31:0]              q_dmem,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [31:0]              ram_data,
    output logic                     ram_wren,
    input  logic [31:0]              ram_q,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [LED_WIDTH-1:0]     led
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          mmio_sel;
    logic [3:0]    offset;
    logic          mmio_wr;
    logic          push;
    logic          pop;
    logic [63:0]   cyc;
    logic [63:0]   snap;
    logic          overflow;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [31:0]   status;
    logic [31:0]   mmio_rdata;

    assign mmio_sel = (address_dmem[31:4] == MMIO_BASE_HI);
    assign offset   = address_dmem[3:0];
    assign mmio_wr  = wren & mmio_sel;
    assign ram_wren = wren & ~mmio_sel;
    assign ram_addr = address_dmem[RAM_ADDR_BITS-1:0];
    assign ram_data = data;

    assign push     = mmio_wr && (offset == OFF_TX_DATA);
    assign pop      = tx_valid & tx_ready;
    assign tx_valid = ~empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (data[7:0]),
        .pop       (pop),
        .head      (tx_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc      <= '0;
            snap     <= '0;
            led      <= '0;
            overflow <= 1'b0;
        end else begin
            cyc <= cyc + 64'd1;
            // Snapshot takes the value the counter shows during the write cycle.
            if (mmio_wr && (offset == OFF_CYC_LO)) begin
                snap <= cyc;
            end
            if (mmio_wr && (offset == OFF_LED)) begin
                led <= data[LED_WIDTH-1:0];
            end
            // A dropped byte outranks a clear landing in the same cycle.
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (mmio_wr && (offset == OFF_TX_STATUS)) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status                     = '0;
        status[ST_EMPTY]           = empty;
        status[ST_FULL]            = full;
        status[ST_OVF]             = overflow;
        status[ST_COUNT_LSB +: 8]  = 8'(count);
    end

    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_CYC_LO:    mmio_rdata = snap[31:0];
            OFF_CYC_HI:    mmio_rdata = snap[63:32];
            OFF_TX_STATUS: mmio_rdata = status;
            OFF_LED:       mmio_rdata = 32'(led);
            default:       mmio_rdata = '0;
        endcase
    end

    assign q_dmem = mmio_sel ? mmio_rdata : ram_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// tb/tb_dmem_mmio_bridge.sv - scoreboard bench for dmem_mmio_bridge
module tb_dmem_mmio_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic [11:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] led;

    dmem_mmio_bridge dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .led          (led)
    );

    always #5 clock = ~clock;

    localparam int S_Q = 0, S_LED = 1, S_TXV = 2, S_RWREN = 3, S_RADDR = 4, S_RDATA = 5;

    typedef struct {
        int unsigned stamp;
        int          sel;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t       chkq[$];
    logic [7:0] txq[$];
    int         checks = 0;
    int         errors = 0;
    int unsigned cyc_tb = 0;
    int         rel = 0;

    always @(posedge clock) cyc_tb <= cyc_tb + 1;

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            S_Q:     return 64'(q_dmem);
            S_LED:   return 64'(led);
            S_TXV:   return 64'(tx_valid);
            S_RWREN: return 64'(ram_wren);
            S_RADDR: return 64'(ram_addr);
            S_RDATA: return 64'(ram_data);
            default: return '1;
        endcase
    endfunction

    // Monitor: compares queued expectations for this cycle and every drained byte.
    always @(negedge clock) begin
        while (chkq.size() != 0 && chkq[0].stamp <= cyc_tb) begin
            chk_t c;
            logic [63:0] a;
            c = chkq.pop_front();
            a = actual(c.sel);
            checks++;
            if (c.stamp != cyc_tb) begin
                errors++;
                $display("FAIL %s stale expectation stamp %0d now %0d", c.name, c.stamp, cyc_tb);
            end else if (a !== c.exp) begin
                errors++;
                $display("FAIL %s got 0x%0h expected 0x%0h", c.name, a, c.exp);
            end
        end
        if (reset && tx_valid && tx_ready) begin
            checks++;
            if (txq.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got 0x%0h expected none", tx_data);
            end else begin
                logic [7:0] e;
                e = txq.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_data got 0x%0h expected 0x%0h", tx_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int sel, input logic [63:0] exp);
        chk_t c;
        c.stamp = cyc_tb;
        c.sel   = sel;
        c.exp   = exp;
        c.name  = name;
        chkq.push_back(c);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        address_dmem = a;
        data         = d;
        wren         = w;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        rel++;
        drive(32'h0, 32'h0, 1'b0);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        drive(a, d, 1'b1);
        tick();
    endtask

    task automatic lw(input logic [31:0] a, input logic [31:0] exp, input string name);
        drive(a, 32'h0, 1'b0);
        chk(name, S_Q, 64'(exp));
        tick();
    endtask

    task automatic drain(input string name, input int n);
        int k;
        k = 0;
        tx_ready = 1'b1;
        while (tx_valid && k < 40) begin
            tick();
            k++;
        end
        tx_ready = 1'b0;
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL %s drain cycles got %0d expected %0d", name, k, n);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b1;
        rel = 0;
    endtask

    initial begin
        #1;
        do_reset(2);
        // Cycle 0 after release.
        chk("rst_led", S_LED, 64'h0);
        chk("rst_txv", S_TXV, 64'h0);
        lw(32'hFFFFFFF3, 32'h00000001, "rst_status");
        lw(32'hFFFFFFF0, 32'h00000000, "rst_snap");

        drive(32'h00000005, 32'hDEADBEEF, 1'b1);
        chk("ram_wren_on", S_RWREN, 64'h1);
        chk("ram_addr", S_RADDR, 64'h5);
        chk("ram_data", S_RDATA, 64'hDEADBEEF);
        tick();
        drive(32'hFFFFFFF4, 32'h00001234, 1'b1);
        chk("ram_wren_mmio", S_RWREN, 64'h0);
        tick();
        chk("led_write", S_LED, 64'h1234);
        ram_q = 32'h0000CAFE;
        lw(32'h00000005, 32'h0000CAFE, "ram_read");
        lw(32'hFFFFFFF4, 32'h00001234, "led_read");
        ram_q = 32'h00000055;
        drive(32'hFFFFFFEF, 32'h0, 1'b0);
        chk("below_mmio_addr", S_RADDR, 64'hFEF);
        lw(32'hFFFFFFEF, 32'h00000055, "below_mmio_read");
        sw(32'hFFFFFFF7, 32'hFFFFFFFF);
        lw(32'hFFFFFFF7, 32'h0, "unmapped_read");

        while (rel < 10) tick();
        sw(32'hFFFFFFF0, 32'h12345678);
        lw(32'hFFFFFFF0, 32'd10, "snap_lo");
        lw(32'hFFFFFFF1, 32'd0, "snap_hi");
        for (int i = 0; i < 20; i++) tick();
        lw(32'hFFFFFFF0, 32'd10, "snap_lo_held");
        lw(32'hFFFFFFF2, 32'd0, "txdata_read");

        for (int i = 0; i < 9; i++) begin
            drive(32'hFFFFFFF2, 32'(8'h41 + i), 1'b1);
            if (i == 0) chk("txv_same_cycle", S_TXV, 64'h0);
            if (i == 1) chk("txv_next_cycle", S_TXV, 64'h1);
            if (i < 8) txq.push_back(8'(8'h41 + i));
            tick();
        end
        lw(32'hFFFFFFF3, 32'h00000806, "status_overflow");
        drain("fill_drain", 8);
        sw(32'hFFFFFFF3, 32'h0);
        lw(32'hFFFFFFF3, 32'h00000001, "status_cleared");

        for (int i = 0; i < 8; i++) begin
            txq.push_back(8'(8'h61 + i));
            sw(32'hFFFFFFF2, 32'(8'h61 + i));
        end
        lw(32'hFFFFFFF3, 32'h00000802, "status_full");
        tx_ready = 1'b1;
        txq.push_back(8'h5A);
        sw(32'hFFFFFFF2, 32'h0000005A);
        tx_ready = 1'b0;
        lw(32'hFFFFFFF3, 32'h00000802, "status_full_pushpop");
        drain("full_pushpop_drain", 8);

        txq.push_back(8'h71);
        sw(32'hFFFFFFF2, 32'h71);
        tx_ready = 1'b1;
        txq.push_back(8'h72);
        sw(32'hFFFFFFF2, 32'h72);
        tx_ready = 1'b0;
        lw(32'hFFFFFFF3, 32'h00000100, "status_count1");
        drain("count1_drain", 1);

        for (int i = 0; i < 3; i++) sw(32'hFFFFFFF2, 32'(8'h81 + i));
        sw(32'hFFFFFFF4, 32'h000000FF);
        chk("led_ff", S_LED, 64'hFF);
        chk("txv_before_reset", S_TXV, 64'h1);
        tick();
        do_reset(1);
        chk("mid_rst_txv", S_TXV, 64'h0);
        chk("mid_rst_led", S_LED, 64'h0);
        lw(32'hFFFFFFF3, 32'h00000001, "mid_rst_status");
        while (rel < 3) tick();
        sw(32'hFFFFFFF0, 32'h0);
        lw(32'hFFFFFFF0, 32'd3, "cyc_restart");

        tick();
        tick();
        checks++;
        if (chkq.size() != 0 || txq.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d/%0d expected 0/0", chkq.size(), txq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
